full_handshake_rx_buf: RTL

- Next-generation RX endpoint of the four-phase (req/ack) clock-domain-crossing handshake.
- Adds three things:
  - a parametrised req synchroniser depth;
  - a DEPTH-entry receive FIFO with valid/ready drain on the RX side;
  - back-pressure to TX: ack is withheld while the FIFO is full, so no word is ever dropped.
- Sits in the RX clock domain, between the CDC boundary and RX-side consumers (bus bridges, debug/JTAG paths).

---
 rtl/cdc_pkg.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 68 ++++++
 rtl/full_handshake_rx_buf.sv | 109 ++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the RX handshake endpoint: FSM state encoding and
// width helpers for FIFO pointers and occupancy counters.
package cdc_pkg;

    // One-hot handshake states; any other pattern is treated as illegal.
    typedef enum logic [1:0] {
        HS_IDLE          = 2'b01,
        HS_WAIT_DEASSERT = 2'b10
    } hs_state_e;

    // Pointer width: enough bits to address DEPTH entries, never zero.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Count width: must be able to represent the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with arbitrary (non power-of-two) depth.
// Pointers wrap by explicit compare; push when full and pop when empty are ignored.
module sync_fifo_fwft
    import cdc_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = ptr_width(DEPTH),
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/full_handshake_rx_buf.sv
// RX endpoint of a four-phase req/ack CDC handshake. Each req high phase
// pushes one word into a receive FIFO; ack is withheld while the FIFO is
// full, so TX is back-pressured and no word is lost.
module full_handshake_rx_buf
    import cdc_pkg::*;
#(
    parameter  int DW          = 32,
    parameter  int DEPTH       = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [DW-1:0] req_data_i,
    output logic          ack_o,
    output logic          recv_valid_o,
    input  logic          recv_ready_i,
    output logic [DW-1:0] recv_data_o,
    output logic [CW-1:0] count_o,
    output logic          stall_o
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   req_s;
    hs_state_e              state_reg;
    hs_state_e              state_next;
    logic                   ack_reg;
    logic                   ack_next;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   stall;

    assign req_s = sync_reg[SYNC_STAGES-1];

    // Synchroniser: req_i only ever enters through this flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], req_i};
        end
    end

    // Handshake state and ack register; ack_o comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HS_IDLE;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
        end
    end

    // Next-state logic; the full check uses registered occupancy, so a pop on
    // the same edge does not make room until the following edge.
    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        fifo_push  = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            HS_IDLE: begin
                if (req_s) begin
                    if (!fifo_full) begin
                        fifo_push  = 1'b1;
                        ack_next   = 1'b1;
                        state_next = HS_WAIT_DEASSERT;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            HS_WAIT_DEASSERT: begin
                if (req_s) begin
                    ack_next = 1'b1;
                end else begin
                    state_next = HS_IDLE;
                end
            end
            default: begin
                state_next = HS_IDLE;
                ack_next   = 1'b0;
            end
        endcase
    end

    sync_fifo_fwft #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (req_data_i),
        .pop       (recv_ready_i),
        .pop_data  (recv_data_o),
        .count     (count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ack_o        = ack_reg;
    assign recv_valid_o = !fifo_empty;
    assign stall_o      = stall;

endmodule
